// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, field positions, exception codes
// and the exception entry address exported for the fetch-stage PC mux.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IM_LO_BIT    = 10;
  localparam int IM_HI_BIT    = 15;
  localparam int EXC_LO_BIT   = 2;
  localparam int EXC_HI_BIT   = 6;
  localparam int CAUSE_BD_BIT = 31;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE   = 32'h2023_0007;

  // A delay-slot victim restarts at the branch one word earlier (wraps mod 2^32).
  function automatic logic [31:0] epc_target(input logic [31:0] vpc, input logic bd);
    logic [31:0] word_pc;
    word_pc = vpc & 32'hFFFF_FFFC;
    return bd ? (word_pc - 32'd4) : word_pc;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational request arbiter: qualifies interrupts and exceptions against
// SR and selects the ExcCode to latch (interrupts win).
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hw_int_i,
  input  logic [5:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [4:0] exc_code_i,
  output logic       req_o,
  output logic [4:0] exc_code_o
);

  logic int_req_s;
  logic exc_req_s;

  always_comb begin
    int_req_s  = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
    exc_req_s  = (exc_code_i != 5'd0) & ~exl_i;
    req_o      = int_req_s | exc_req_s;
    exc_code_o = int_req_s ? EXC_INT : exc_code_i;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// M-stage CP0: SR/Cause/EPC state, mfc0/mtc0 access, eret and exception entry.
// Build option CP0_PRID_EN makes index 15 return PRID_VALUE instead of 0.
module cp0_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  sr_im_q,     sr_im_d;
  logic        sr_exl_q,    sr_exl_d;
  logic        sr_ie_q,     sr_ie_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,       epc_d;

  logic        req_s;
  logic [4:0]  exc_sel_s;
  logic        wr_sr_s;
  logic        wr_epc_s;
  logic [31:0] sr_s;
  logic [31:0] cause_s;

  cp0_req_arb u_req_arb (
    .hw_int_i   (HWInt),
    .im_i       (sr_im_q),
    .ie_i       (sr_ie_q),
    .exl_i      (sr_exl_q),
    .exc_code_i (ExcCodeIn),
    .req_o      (req_s),
    .exc_code_o (exc_sel_s)
  );

  // Exception entry beats eret, which beats mtc0; eret still lets the mtc0 land first.
  always_comb begin
    wr_sr_s     = en & (CP0Add == CP0_SR);
    wr_epc_s    = en & (CP0Add == CP0_EPC);
    cause_ip_d  = HWInt;
    sr_im_d     = (!req_s && wr_sr_s) ? CP0In[IM_HI_BIT:IM_LO_BIT] : sr_im_q;
    sr_ie_d     = (!req_s && wr_sr_s) ? CP0In[SR_IE_BIT] : sr_ie_q;
    sr_exl_d    = req_s    ? 1'b1 :
                  EXLClr   ? 1'b0 :
                  wr_sr_s  ? CP0In[SR_EXL_BIT] : sr_exl_q;
    cause_bd_d  = req_s ? BDIn : cause_bd_q;
    cause_exc_d = req_s ? exc_sel_s : cause_exc_q;
    epc_d       = req_s    ? epc_target(VPC, BDIn) :
                  wr_epc_s ? (CP0In & 32'hFFFF_FFFC) : epc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_s    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    cause_s = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
    case (CP0Add)
      CP0_SR:    CP0Out = sr_s;
      CP0_CAUSE: CP0Out = cause_s;
      CP0_EPC:   CP0Out = epc_q;
`ifdef CP0_PRID_EN
      CP0_PRID:  CP0Out = PRID_VALUE;
`else
      CP0_PRID:  CP0Out = 32'd0;
`endif
      default:   CP0Out = 32'd0;
    endcase
  end

  assign EPCOut = epc_q;
  assign Req    = req_s;

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor 0 exception/interrupt controller at the M stage.
- Consumes the exception code and branch-delay flag carried down the pipeline registers (F_EXCCode/F_delayed lineage).
- Produces the single-bit Req that flushes every pipeline register and steers the FD register to fetch the handler at 0x0000_4180.
- Holds SR, Cause and EPC. Services mfc0/mtc0 accesses and eret.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception entry PC. Exported for the PC mux; the block itself does not use it internally.
- PRID_VALUE, 32'h2023_0007, constant returned for register 15. Used only when CP0_PRID_EN is defined.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  mtc0 write enable (M-stage mtc0)
- CP0Add  in  5  register index for read/write (12=SR, 13=Cause, 14=EPC, 15=PRId)
- CP0In  in  32  mtc0 write data
- CP0Out  out  32  mfc0 read data (combinational)
- VPC  in  32  PC of the M-stage instruction, or of the bubble slot
- BDIn  in  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  in  5  M-stage exception code; 0 = none
- HWInt  in  6  external interrupt lines, level-sensitive
- EXLClr  in  1  eret at M stage
- EPCOut  out  32  current EPC (eret target)
- Req  out  1  take exception/interrupt this cycle (combinational)

Behaviour:
- Register fields:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read as 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read as 0.
  - EPC: 32 bits.
- Reset (reset=0, asynchronous): SR, Cause and EPC all clear to 0. With no stimulus, Req=0 and CP0Out=0.
- IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- ExcReq = (ExcCodeIn != 0) & !SR.EXL.
- Req = IntReq | ExcReq. Interrupt has priority over exception.
- Every posedge: Cause.IP <= HWInt, unconditionally.
- On a posedge with Req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? {VPC[31:2]-1, 2'b00} : {VPC[31:2], 2'b00}.
  - Any mtc0 in the same cycle is discarded.
- Else if EXLClr=1: SR.EXL <= 0. A simultaneous mtc0 is still applied, and EXL is cleared afterwards.
- Else if en=1, write by CP0Add:
  - 12: IM, EXL and IE only.
  - 14: full 32 bits, bits[1:0] forced to 0.
  - 13 and 15: read-only, writes ignored.
  - Any other index: ignored.
- CP0Out: read mux over SR/Cause/EPC; returns 0 for unmapped indices.
- EPCOut = EPC register. Not bypassed from a same-cycle mtc0.
- Wrap-around: VPC=0 with BDIn=1 gives EPC=32'hFFFF_FFFC (modulo 2^32).
- Nested events while EXL=1: ignored, Req stays 0, and IP still tracks HWInt.
- Reset asserted mid-handler: EXL clears immediately; no pending Req is remembered.

Optional Feature:
- CP0_PRID_EN
  - Defined: CP0Add=15 reads PRID_VALUE.
  - Undefined: CP0Add=15 reads 0. No other behaviour changes.

Decomposition:
- Shared package cp0_pkg holds:
  - register index constants: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15;
  - field bit positions;
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12;
  - HANDLER_ADDR default.
- One sub-module is natural: cp0_req_arb, the combinational IntReq/ExcReq/Req and ExcCode select. The register file stays in cp0_ctrl.

Test Plan:
- Reset sequencing: pulse reset low mid-cycle -> SR/Cause/EPC read 0 immediately, before the next clk edge; Req=0.
- Exception capture: ExcCodeIn=10, VPC=32'h0000_3008, BDIn=0 -> Req=1 the same cycle. Next cycle SR=32'h0000_0002, Cause=32'h0000_0028, EPC=32'h0000_3008.
- Delay-slot exception: BDIn=1, VPC=32'h0000_3010, ExcCodeIn=12 -> EPC=32'h0000_300C, Cause=32'h8000_0030.
- Interrupt gating and priority: mtc0 SR=32'h0000_0401, then HWInt=6'b000001 with ExcCodeIn=4 -> Req=1, Cause.ExcCode=0, IP=1. A second HWInt pulse while EXL=1 -> Req=0.
- eret with conflicting mtc0: EXL=1, EXLClr=1 with mtc0 SR=32'h0000_0403 in the same cycle -> SR=32'h0000_0401. Then Req=1 with en=1 writing EPC -> the write is discarded.
- Build-option and read-only checks: mfc0 15 -> PRID_VALUE with CP0_PRID_EN defined, 0 without it. mtc0 Cause=32'hFFFF_FFFF -> Cause unchanged.
